// File: rtl/fetch_refill_unit_pkg.sv
// Shared types and helpers for the fetch unit and its refill engine.
package fetch_refill_unit_pkg;

  localparam int unsigned TAG_W    = 51;
  localparam int unsigned INDEX_W  = 8;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StData,
    StWrite
  } refillState_e;

  // Line-aligned memory address for a {tag, index} pair.
  function automatic logic [0:ADDR_W-1] composeLineAddr(input logic [0:TAG_W-1]   tag,
                                                       input logic [0:INDEX_W-1] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fetch_refill_unit_pending_slot.sv
// One-entry buffer for a miss that arrives while a refill is already in flight.
module refill_pending_slot
  import fetch_refill_unit_pkg::*;
(
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                flush_i,
  input  logic                missValid_i,
  input  logic                acceptEn_i,
  input  logic [0:TAG_W-1]    missTag_i,
  input  logic [0:INDEX_W-1]  missIndex_i,
  input  logic [0:OFFSET_W-1] missOffset_i,
  input  logic [0:TAG_W-1]    inflightTag_i,
  input  logic [0:INDEX_W-1]  inflightIndex_i,
  input  logic                load_i,
  output logic                pendValid_o,
  output logic [0:TAG_W-1]    pendTag_o,
  output logic [0:INDEX_W-1]  pendIndex_o,
  output logic [0:OFFSET_W-1] pendOffset_o
);

  logic                validQ, validD;
  logic [0:TAG_W-1]    tagQ;
  logic [0:INDEX_W-1]  indexQ;
  logic [0:OFFSET_W-1] offsetQ;
  logic                dupInflight;
  logic                store;

  // Decide whether the incoming miss is captured; flush beats both store and hold.
  always_comb begin
    dupInflight = (missTag_i == inflightTag_i) && (missIndex_i == inflightIndex_i);
    // A full slot drops any further miss, which also covers a repeat of the pending line.
    store       = missValid_i && acceptEn_i && !flush_i && !validQ && !dupInflight;
    validD      = validQ;
    if (flush_i || load_i) begin
      validD = 1'b0;
    end else if (store) begin
      validD = 1'b1;
    end
  end

  // Slot storage.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      validQ  <= 1'b0;
      tagQ    <= '0;
      indexQ  <= '0;
      offsetQ <= '0;
    end else begin
      validQ <= validD;
      if (store) begin
        tagQ    <= missTag_i;
        indexQ  <= missIndex_i;
        offsetQ <= missOffset_i;
      end
    end
  end

  assign pendValid_o  = validQ;
  assign pendTag_o    = tagQ;
  assign pendIndex_o  = indexQ;
  assign pendOffset_o = offsetQ;

endmodule

// File: rtl/fetch_refill_unit.sv
// Refill engine: turns a fetch miss into a 4-beat memory read and a one-cycle cache write.
module fetch_refill_unit
  import fetch_refill_unit_pkg::*;
#(
  parameter int unsigned MEM_BUS_WIDTH  = 64,
  parameter int unsigned LINE_WIDTH     = LINE_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   flushPipeline_i,
  input  logic                   isCacheMiss_i,
  input  logic [0:TAG_W-1]       missTag_i,
  input  logic [0:INDEX_W-1]     missIndex_i,
  input  logic [0:OFFSET_W-1]    missOffset_i,
  output logic                   memReq_o,
  output logic [0:ADDR_W-1]      memAddr_o,
  input  logic                   memReqAck_i,
  input  logic [0:MEM_BUS_WIDTH-1] memData_i,
  input  logic                   memDataValid_i,
  output logic [0:TAG_W-1]       newTag_o,
  output logic [0:INDEX_W-1]     newIndex_o,
  output logic [0:OFFSET_W-1]    newOffset_o,
  output logic [0:LINE_WIDTH-1]  newCacheline_o,
  output logic                   cacheUpdateEnable_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned BEATS      = LINE_WIDTH / MEM_BUS_WIDTH;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned BEAT_SHIFT = $clog2(MEM_BUS_WIDTH);
  localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYCLES + 1);

  refillState_e        stateQ, stateD;
  logic [0:TAG_W-1]    tagQ, tagD;
  logic [0:INDEX_W-1]  indexQ, indexD;
  logic [0:OFFSET_W-1] offsetQ, offsetD;
  logic [BEAT_W-1:0]   beatQ, beatD;
  logic [CNT_W-1:0]    toCntQ, toCntD;
  logic [0:LINE_WIDTH-1] lineQ, lineD;
  logic                timeoutD;
  logic                loadPend;

  logic                memReqQ, updQ, busyQ, timeoutQ;
  logic [0:ADDR_W-1]   memAddrQ;
  logic [0:TAG_W-1]    newTagQ;
  logic [0:INDEX_W-1]  newIndexQ;

  logic                pendValid;
  logic [0:TAG_W-1]    pendTag;
  logic [0:INDEX_W-1]  pendIndex;
  logic [0:OFFSET_W-1] pendOffset;

  // The miss offset is carried along with the line but never shapes the address.
  logic unusedOffset;
  assign unusedOffset = ^offsetQ;

  refill_pending_slot uPendingSlot (
    .clock_i         (clock_i),
    .reset_n_i       (reset_n_i),
    .flush_i         (flushPipeline_i),
    .missValid_i     (isCacheMiss_i),
    .acceptEn_i      (stateQ != StIdle),
    .missTag_i       (missTag_i),
    .missIndex_i     (missIndex_i),
    .missOffset_i    (missOffset_i),
    .inflightTag_i   (tagQ),
    .inflightIndex_i (indexQ),
    .load_i          (loadPend),
    .pendValid_o     (pendValid),
    .pendTag_o       (pendTag),
    .pendIndex_o     (pendIndex),
    .pendOffset_o    (pendOffset)
  );

  // Next-state, beat assembly and stall/timeout bookkeeping.
  always_comb begin
    stateD   = stateQ;
    tagD     = tagQ;
    indexD   = indexQ;
    offsetD  = offsetQ;
    beatD    = beatQ;
    lineD    = lineQ;
    timeoutD = 1'b0;
    loadPend = 1'b0;
    unique case (stateQ)
      StIdle: begin
        // A flush drops the unstarted miss, whether buffered or arriving now.
        if (!flushPipeline_i) begin
          if (pendValid) begin
            loadPend = 1'b1;
            tagD     = pendTag;
            indexD   = pendIndex;
            offsetD  = pendOffset;
            stateD   = StReq;
          end else if (isCacheMiss_i) begin
            tagD    = missTag_i;
            indexD  = missIndex_i;
            offsetD = missOffset_i;
            stateD  = StReq;
          end
        end
      end
      StReq: begin
        if (memReqAck_i) begin
          beatD  = '0;
          stateD = StData;
        end else if (toCntQ == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeoutD = 1'b1;
        end
      end
      StData: begin
        if (memDataValid_i) begin
          lineD[{beatQ, {BEAT_SHIFT{1'b0}}} +: MEM_BUS_WIDTH] = memData_i;
          beatD = beatQ + 1'b1;
          if (beatQ == BEAT_W'(BEATS - 1)) begin
            stateD = StWrite;
          end
        end else if (toCntQ == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Reissue from scratch; beats already captured get overwritten.
          timeoutD = 1'b1;
          beatD    = '0;
          stateD   = StReq;
        end
      end
      StWrite: begin
        if (pendValid && !flushPipeline_i) begin
          loadPend = 1'b1;
          tagD     = pendTag;
          indexD   = pendIndex;
          offsetD  = pendOffset;
          stateD   = StReq;
        end else begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase

    // Counts stalled cycles; any progress or leaving the waiting states restarts it.
    if ((stateD != stateQ) || timeoutD || (stateQ == StData && memDataValid_i) ||
        !(stateD inside {StReq, StData})) begin
      toCntD = '0;
    end else begin
      toCntD = toCntQ + 1'b1;
    end
  end

  // State and registered outputs, all derived from next-state values.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stateQ    <= StIdle;
      tagQ      <= '0;
      indexQ    <= '0;
      offsetQ   <= '0;
      beatQ     <= '0;
      toCntQ    <= '0;
      lineQ     <= '0;
      memReqQ   <= 1'b0;
      memAddrQ  <= '0;
      updQ      <= 1'b0;
      busyQ     <= 1'b0;
      timeoutQ  <= 1'b0;
      newTagQ   <= '0;
      newIndexQ <= '0;
    end else begin
      stateQ    <= stateD;
      tagQ      <= tagD;
      indexQ    <= indexD;
      offsetQ   <= offsetD;
      beatQ     <= beatD;
      toCntQ    <= toCntD;
      lineQ     <= lineD;
      memReqQ   <= (stateD == StReq);
      memAddrQ  <= composeLineAddr(tagD, indexD);
      updQ      <= (stateD == StWrite);
      busyQ     <= (stateD != StIdle);
      timeoutQ  <= timeoutD;
      if (stateD == StWrite) begin
        newTagQ   <= tagD;
        newIndexQ <= indexD;
      end
    end
  end

  assign memReq_o            = memReqQ;
  assign memAddr_o           = memAddrQ;
  assign newTag_o            = newTagQ;
  assign newIndex_o          = newIndexQ;
  assign newOffset_o         = '0;
  assign newCacheline_o      = lineQ;
  assign cacheUpdateEnable_o = updQ;
  assign busy_o              = busyQ;
  assign timeout_o           = timeoutQ;

endmodule

// File: tb/tb_fetch_refill_unit.sv
// Self-checking bench for fetch_refill_unit: table-driven refills plus corner-case sequences.
module tb_fetch_refill_unit;
  import fetch_refill_unit_pkg::*;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          miss;
  logic [0:50]   missTag;
  logic [0:7]    missIndex;
  logic [0:4]    missOffset;
  logic          memReq;
  logic [0:63]   memAddr;
  logic          memReqAck;
  logic [0:63]   memData;
  logic          memDataValid;
  logic [0:50]   newTag;
  logic [0:7]    newIndex;
  logic [0:4]    newOffset;
  logic [0:255]  newCacheline;
  logic          upd;
  logic          busy;
  logic          timeout;

  always #5 clock = ~clock;

  fetch_refill_unit dut (
    .clock_i             (clock),
    .reset_n_i           (reset_n),
    .flushPipeline_i     (flush),
    .isCacheMiss_i       (miss),
    .missTag_i           (missTag),
    .missIndex_i         (missIndex),
    .missOffset_i        (missOffset),
    .memReq_o            (memReq),
    .memAddr_o           (memAddr),
    .memReqAck_i         (memReqAck),
    .memData_i           (memData),
    .memDataValid_i      (memDataValid),
    .newTag_o            (newTag),
    .newIndex_o          (newIndex),
    .newOffset_o         (newOffset),
    .newCacheline_o      (newCacheline),
    .cacheUpdateEnable_o (upd),
    .busy_o              (busy),
    .timeout_o           (timeout)
  );

  typedef struct {
    logic [50:0]  tag;
    logic [7:0]   idx;
    logic [255:0] line;
  } upd_t;

  typedef struct {
    logic [50:0]      tag;
    logic [7:0]       idx;
    logic [4:0]       off;
    logic [3:0][63:0] beats;
    int               gap;
    logic [63:0]      addr;
    logic [255:0]     line;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   nUpd = 0;
  upd_t expQ[$];
  vec_t vecs[3];

  localparam logic [63:0] B0 = 64'hFFFFFFFF_EEEEEEEE;
  localparam logic [63:0] B1 = 64'hDDDDDDDD_CCCCCCCC;
  localparam logic [63:0] B2 = 64'hBBBBBBBB_AAAAAAAA;
  localparam logic [63:0] B3 = 64'h99999999_88888888;
  localparam logic [255:0] LINE_A =
    256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic vec_t mkVec(logic [50:0] t, logic [7:0] i, logic [4:0] o, logic [63:0] b0,
                                 logic [63:0] b1, logic [63:0] b2, logic [63:0] b3, int gap,
                                 logic [63:0] addr, logic [255:0] line);
    vec_t v;
    v.tag = t; v.idx = i; v.off = o;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
    v.gap = gap; v.addr = addr; v.line = line;
    return v;
  endfunction

  function automatic void pushExp(logic [50:0] t, logic [7:0] i, logic [255:0] line);
    upd_t e;
    e.tag = t; e.idx = i; e.line = line;
    expQ.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issueMiss(input logic [50:0] t, input logic [7:0] i, input logic [4:0] o);
    miss = 1'b1; missTag = t; missIndex = i; missOffset = o;
    tick();
    miss = 1'b0;
  endtask

  task automatic waitReq(input string nm, input logic [63:0] expAddr);
    int n = 0;
    while (!memReq && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " req"}, memReq, 1);
    chk({nm, " addr"}, memAddr, expAddr);
  endtask

  task automatic ackReq(input string nm);
    memReqAck = 1'b1;
    tick();
    memReqAck = 1'b0;
    chk({nm, " req drop"}, memReq, 0);
  endtask

  task automatic sendBeat(input logic [63:0] d, input int gap);
    repeat (gap) tick();
    memData = d; memDataValid = 1'b1;
    tick();
    memDataValid = 1'b0; memData = '0;
  endtask

  // Scoreboard side: every update pulse is matched against the oldest expected line.
  task automatic monitor();
    upd_t e;
    forever begin
      @(negedge clock);
      if (reset_n && upd) begin
        nUpd++;
        if (expQ.size() == 0) begin
          chk("spurious update", upd, 0);
        end else begin
          e = expQ.pop_front();
          chk("upd tag", newTag, e.tag);
          chk("upd index", newIndex, e.idx);
          chk("upd offset", newOffset, 0);
          chk("upd line", newCacheline, e.line);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int startUpd;
    int nTo;
    int nLow;
    int nReq;

    vecs[0] = mkVec(51'd5, 8'd8, 5'd4, B0, B1, B2, B3, 0, 64'hA100, LINE_A);
    vecs[1] = mkVec(51'd5, 8'd8, 5'd4, B0, B1, B2, B3, 3, 64'hA100, LINE_A);
    vecs[2] = mkVec(51'h1234, 8'hFF, 5'd1, 64'h01234567_89ABCDEF, 64'h11111111_11111111,
                    64'h22222222_22222222, 64'h33333333_33333333, 1, 64'h2469FE0,
                    256'h01234567_89ABCDEF_11111111_11111111_22222222_22222222_33333333_33333333);

    reset_n = 1'b0; flush = 1'b0; miss = 1'b0; missTag = '0; missIndex = '0; missOffset = '0;
    memReqAck = 1'b0; memData = '0; memDataValid = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    chk("reset memReq", memReq, 0);
    chk("reset memAddr", memAddr, 0);
    chk("reset newCacheline", newCacheline, 0);
    chk("reset upd", upd, 0);
    chk("reset busy", busy, 0);
    chk("reset timeout", timeout, 0);
    reset_n = 1'b1;
    tick();

    // Table-driven refills, each starting from IDLE.
    for (int v = 0; v < 3; v++) begin
      pushExp(vecs[v].tag, vecs[v].idx, vecs[v].line);
      issueMiss(vecs[v].tag, vecs[v].idx, vecs[v].off);
      chk($sformatf("vec%0d req latency", v), memReq, 1);
      chk($sformatf("vec%0d addr", v), memAddr, vecs[v].addr);
      chk($sformatf("vec%0d busy", v), busy, 1);
      ackReq($sformatf("vec%0d", v));
      for (int b = 0; b < 4; b++) sendBeat(vecs[v].beats[b], vecs[v].gap);
      chk($sformatf("vec%0d pulse", v), upd, 1);
      tick();
      chk($sformatf("vec%0d pulse width", v), upd, 0);
      chk($sformatf("vec%0d idle", v), busy, 0);
    end

    // Duplicate miss dropped, distinct miss buffered and served afterwards.
    startUpd = nUpd;
    pushExp(51'd5, 8'd8, LINE_A);
    issueMiss(51'd5, 8'd8, 5'd4);
    waitReq("dup1", 64'hA100);
    ackReq("dup1");
    sendBeat(B0, 0);
    issueMiss(51'd5, 8'd8, 5'd2);
    pushExp(51'd5, 8'd9, {64'h0A0A0A0A_0A0A0A0A, 64'h0B0B0B0B_0B0B0B0B,
                          64'h0C0C0C0C_0C0C0C0C, 64'h0D0D0D0D_0D0D0D0D});
    issueMiss(51'd5, 8'd9, 5'd0);
    sendBeat(B1, 0); sendBeat(B2, 0); sendBeat(B3, 0);
    waitReq("dup2", 64'hA120);
    ackReq("dup2");
    sendBeat(64'h0A0A0A0A_0A0A0A0A, 0); sendBeat(64'h0B0B0B0B_0B0B0B0B, 0);
    sendBeat(64'h0C0C0C0C_0C0C0C0C, 0); sendBeat(64'h0D0D0D0D_0D0D0D0D, 0);
    repeat (5) tick();
    chk("dup pulse count", nUpd - startUpd, 2);
    chk("dup idle", busy, 0);

    // Buffered miss is flushed; in-flight line still completes.
    startUpd = nUpd;
    pushExp(51'd5, 8'd8, LINE_A);
    issueMiss(51'd5, 8'd8, 5'd4);
    waitReq("flush", 64'hA100);
    ackReq("flush");
    sendBeat(B0, 0);
    issueMiss(51'd7, 8'd3, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sendBeat(B1, 0); sendBeat(B2, 0); sendBeat(B3, 0);
    chk("flush pulse", upd, 1);
    tick();
    chk("flush busy falls", busy, 0);
    nReq = 0;
    for (int c = 0; c < 20; c++) begin
      if (memReq) nReq++;
      tick();
    end
    chk("flush no reissue", nReq, 0);
    chk("flush pulse count", nUpd - startUpd, 1);

    // Withheld ack: one timeout, request never drops.
    pushExp(51'd5, 8'd8, LINE_A);
    issueMiss(51'd5, 8'd8, 5'd4);
    waitReq("to", 64'hA100);
    nTo = 0; nLow = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (timeout) nTo++;
      if (!memReq) nLow++;
    end
    chk("timeout pulses", nTo, 1);
    chk("timeout req held", nLow, 0);
    chk("timeout addr", memAddr, 64'hA100);
    ackReq("to");
    sendBeat(B0, 0); sendBeat(B1, 0); sendBeat(B2, 0); sendBeat(B3, 0);
    repeat (3) tick();

    // Asynchronous reset mid-refill: outputs clear at once, late beats ignored.
    startUpd = nUpd;
    issueMiss(51'd5, 8'd8, 5'd4);
    waitReq("rst", 64'hA100);
    ackReq("rst");
    sendBeat(B0, 0); sendBeat(B1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst memReq", memReq, 0);
    chk("rst memAddr", memAddr, 0);
    chk("rst newTag", newTag, 0);
    chk("rst newIndex", newIndex, 0);
    chk("rst newOffset", newOffset, 0);
    chk("rst newCacheline", newCacheline, 0);
    chk("rst upd", upd, 0);
    chk("rst busy", busy, 0);
    chk("rst timeout", timeout, 0);
    #3 reset_n = 1'b1;
    sendBeat(B2, 0); sendBeat(B3, 0);
    repeat (10) tick();
    chk("rst no pulse", nUpd - startUpd, 0);
    chk("rst idle", busy, 0);
    chk("scoreboard drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
